// File: rtl/axis_checker_pkg.sv
// Shared types and helpers for axis_multi_sink_checker and its per-channel ready generator.
package axis_checker_pkg;

  typedef enum logic [1:0] {
    RDY_ALWAYS = 2'd0,
    RDY_HALF   = 2'd1,
    RDY_3Q     = 2'd2
  } rdy_mode_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Right-shifting Galois taps for x^16 + x^14 + x^13 + x^11 + 1
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {1'b0, s[15:1]} ^ (s[0] ? LFSR_TAPS : 16'h0000);
  endfunction

endpackage

// File: rtl/axis_ready_lfsr.sv
// Per-channel ready generator: 16-bit Galois LFSR followed by the ready-mode decode.
module axis_ready_lfsr
  import axis_checker_pkg::*;
#(
  parameter logic [15:0] SEED       = 16'hACE1,
  parameter int          READY_MODE = 1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic load_i,
  input  logic adv_i,
  output logic rdy_o
);

  localparam rdy_mode_e MODE = rdy_mode_e'(READY_MODE[1:0]);

  logic [15:0] lfsr_q;
  logic [1:0]  cur;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)       lfsr_q <= SEED;
    else if (load_i) lfsr_q <= lfsr_step(SEED);
    else if (adv_i)  lfsr_q <= lfsr_step(lfsr_q);
  end

  // On a reload cycle decode the seed itself, so every run replays the same ready sequence.
  assign cur = load_i ? SEED[1:0] : lfsr_q[1:0];

  always_comb begin
    case (MODE)
      RDY_HALF: rdy_o = cur[0];
      RDY_3Q:   rdy_o = |cur;
      default:  rdy_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/axis_multi_sink_checker.sv
// Multi-channel AXI-stream sink/checker: LFSR-throttled TREADY, beat compare against a preloaded
// expected memory, mismatch tally and first-error capture. Watchdog under AXIS_CHECKER_TIMEOUT_EN.
module axis_multi_sink_checker
  import axis_checker_pkg::*;
#(
  parameter int          DATA_W      = 16,
  parameter int          NUM_CH      = 5,
  parameter int          DEPTH       = 4,
  parameter int          READY_MODE  = 1,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1,
  parameter int          TIMEOUT_CYC = 100000,
  localparam int         CW          = clog2_min1(NUM_CH),
  localparam int         AW          = clog2_min1(DEPTH),
  localparam int         IW          = clog2_min1(DEPTH + 1),
  localparam int         MW          = clog2_min1(NUM_CH * DEPTH + 1)
) (
  input  logic                     ap_clk,
  input  logic                     ap_rst,
  input  logic                     start,
  input  logic [NUM_CH*DATA_W-1:0] s_tdata,
  input  logic [NUM_CH-1:0]        s_tvalid,
  output logic [NUM_CH-1:0]        s_tready,
  input  logic                     exp_wr_en,
  input  logic [CW-1:0]            exp_wr_ch,
  input  logic [AW-1:0]            exp_wr_addr,
  input  logic [DATA_W-1:0]        exp_wr_data,
  output logic                     busy,
  output logic                     done,
  output logic [MW-1:0]            mismatch_cnt,
  output logic                     first_err_vld,
  output logic [CW-1:0]            first_err_ch,
  output logic [AW-1:0]            first_err_idx,
  output logic                     timed_out
);

  if (NUM_CH < 1 || DEPTH < 1 || TIMEOUT_CYC < 1 || READY_MODE > 2) begin : g_bad_cfg
    $error("axis_multi_sink_checker: unsupported parameter set");
  end

  state_e              state_q;
  logic                busy_q, done_q, restart, all_comp, wd_fire;
  logic [NUM_CH-1:0]   tready_q, tready_d, rdy, acc, comp, comp_d, neq, mis_p0;
  logic [IW-1:0]       idx_q  [NUM_CH];
  logic [AW-1:0]       idx_p0 [NUM_CH];
  logic [DATA_W-1:0]   exp_mem [NUM_CH][DEPTH];
  logic [MW-1:0]       cnt_q, pop;
  logic                ferr_vld_q;
  logic [CW-1:0]       ferr_ch_q, lo_ch;
  logic [AW-1:0]       ferr_idx_q, lo_idx;

  assign restart  = start && (state_q != RUN);
  assign all_comp = &comp;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    axis_ready_lfsr #(
      .SEED       (LFSR_SEED ^ 16'(c + 1)),
      .READY_MODE (READY_MODE)
    ) u_rdy (
      .clk_i  (ap_clk),
      .rst_i  (ap_rst),
      .load_i (restart),
      .adv_i  (state_q == RUN),
      .rdy_o  (rdy[c])
    );
  end

  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      acc[c]      = s_tvalid[c] & tready_q[c];
      comp[c]     = (idx_q[c] == IW'(DEPTH));
      neq[c]      = (s_tdata[c*DATA_W +: DATA_W] != exp_mem[c][idx_q[c][AW-1:0]]);
      comp_d[c]   = !restart && (comp[c] || (acc[c] && idx_q[c] == IW'(DEPTH - 1)));
      tready_d[c] = (restart || (state_q == RUN && !wd_fire)) && !comp_d[c] && rdy[c];
    end
  end

  always_comb begin
    pop    = '0;
    lo_ch  = '0;
    lo_idx = '0;
    for (int c = NUM_CH - 1; c >= 0; c--) begin
      pop = pop + MW'(mis_p0[c]);
      if (mis_p0[c]) begin
        lo_ch  = CW'(c);
        lo_idx = idx_p0[c];
      end
    end
  end

  // Stage p0: accept and compare; stage p1: fold compare flags into tally and first-error capture
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state_q    <= IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      tready_q   <= '0;
      mis_p0     <= '0;
      cnt_q      <= '0;
      ferr_vld_q <= 1'b0;
      ferr_ch_q  <= '0;
      ferr_idx_q <= '0;
      for (int c = 0; c < NUM_CH; c++) idx_q[c] <= '0;
    end else begin
      tready_q <= tready_d;
      case (state_q)
        IDLE, DONE: if (start) begin
          state_q <= RUN;
          busy_q  <= 1'b1;
          done_q  <= 1'b0;
        end
        RUN: if (all_comp || wd_fire) begin
          state_q <= DONE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
      if (restart) begin
        mis_p0     <= '0;
        cnt_q      <= '0;
        ferr_vld_q <= 1'b0;
        ferr_ch_q  <= '0;
        ferr_idx_q <= '0;
        for (int c = 0; c < NUM_CH; c++) idx_q[c] <= '0;
      end else begin
        for (int c = 0; c < NUM_CH; c++) begin
          mis_p0[c] <= acc[c] & neq[c];
          if (acc[c]) idx_q[c] <= idx_q[c] + 1'b1;
        end
        cnt_q <= cnt_q + pop;
        if (!ferr_vld_q && |mis_p0) begin
          ferr_vld_q <= 1'b1;
          ferr_ch_q  <= lo_ch;
          ferr_idx_q <= lo_idx;
        end
      end
    end
  end

  always_ff @(posedge ap_clk) begin
    for (int c = 0; c < NUM_CH; c++) idx_p0[c] <= idx_q[c][AW-1:0];
  end

  always_ff @(posedge ap_clk) begin
    if (exp_wr_en && state_q != RUN && int'(exp_wr_ch) < NUM_CH && int'(exp_wr_addr) < DEPTH)
      exp_mem[exp_wr_ch][exp_wr_addr] <= exp_wr_data;
  end

`ifdef AXIS_CHECKER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] wd_q;
  logic          to_q;

  assign wd_fire = (state_q == RUN) && !all_comp && !(|acc) && (wd_q == TW'(TIMEOUT_CYC - 1));

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      wd_q <= '0;
      to_q <= 1'b0;
    end else if (restart) begin
      wd_q <= '0;
      to_q <= 1'b0;
    end else if (state_q == RUN) begin
      wd_q <= (|acc) ? '0 : wd_q + 1'b1;
      if (wd_fire) to_q <= 1'b1;
    end
  end

  assign timed_out = to_q;
`else
  assign wd_fire   = 1'b0;
  assign timed_out = 1'b0;
`endif

  assign s_tready      = tready_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign mismatch_cnt  = cnt_q;
  assign first_err_vld = ferr_vld_q;
  assign first_err_ch  = ferr_ch_q;
  assign first_err_idx = ferr_idx_q;

endmodule
